// File: rtl/ram_arb_2req.sv
// ram_arb_2req
//   Two-requester front end for a shared simple-dual-port RAM (one write
//   port with byte enables, one read port with 1-cycle registered read data).
//   Each cycle at most one write and one read are granted. Each port has its
//   own round-robin pointer. Read data is routed back to the requester that
//   issued the read, using a registered tag.
//
// Build option
//   RAM_ARB_WR_BYPASS_EN : when defined, a same-cycle same-address write and
//                          read return the newly written bytes (per byte
//                          enable) instead of the old RAM contents.
//
// Ports
//   Clk, Rst_n                 clock, async active-low reset
//   ReqN_Valid/We/Addr/WD/Ben  request from master N (N = 0,1)
//   ReqN_Ready                 combinational grant
//   RspN_Valid/RD              read response pulse, one cycle after grant
//   Ram_WA/WD/WEN/WClk_En      RAM write port
//   Ram_RA/RClk_En/RD          RAM read port
module ram_arb_2req #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int BEN_W  = DATA_W / 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic              Req0_We,
  input  logic [ADDR_W-1:0] Req0_Addr,
  input  logic [DATA_W-1:0] Req0_WD,
  input  logic [BEN_W-1:0]  Req0_Ben,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic              Req1_We,
  input  logic [ADDR_W-1:0] Req1_Addr,
  input  logic [DATA_W-1:0] Req1_WD,
  input  logic [BEN_W-1:0]  Req1_Ben,
  output logic              Rsp0_Valid,
  output logic [DATA_W-1:0] Rsp0_RD,
  output logic              Rsp1_Valid,
  output logic [DATA_W-1:0] Rsp1_RD,
  output logic [ADDR_W-1:0] Ram_WA,
  output logic [DATA_W-1:0] Ram_WD,
  output logic [BEN_W-1:0]  Ram_WEN,
  output logic [ADDR_W-1:0] Ram_RA,
  output logic              Ram_RClk_En,
  output logic              Ram_WClk_En,
  input  logic [DATA_W-1:0] Ram_RD
);

  logic              wr_ptr, rd_ptr;
  logic              wr_c0, wr_c1, rd_c0, rd_c1;
  logic              wr_g0, wr_g1, rd_g0, rd_g1;
  logic              wr_any, rd_any;
  logic [ADDR_W-1:0] wa_q, ra_q;
  logic [DATA_W-1:0] wd_q;
  logic              rsp_pend, rsp_tag;
  logic [DATA_W-1:0] rd_data;

  // Candidates are masked by reset so nothing is granted while Rst_n is low.
  assign wr_c0 = Rst_n & Req0_Valid &  Req0_We;
  assign wr_c1 = Rst_n & Req1_Valid &  Req1_We;
  assign rd_c0 = Rst_n & Req0_Valid & ~Req0_We;
  assign rd_c1 = Rst_n & Req1_Valid & ~Req1_We;

  // Pointer names the preferred requester when both are candidates.
  assign wr_g0 = wr_c0 & (~wr_c1 | ~wr_ptr);
  assign wr_g1 = wr_c1 & (~wr_c0 |  wr_ptr);
  assign rd_g0 = rd_c0 & (~rd_c1 | ~rd_ptr);
  assign rd_g1 = rd_c1 & (~rd_c0 |  rd_ptr);

  assign wr_any = wr_g0 | wr_g1;
  assign rd_any = rd_g0 | rd_g1;

  assign Req0_Ready = wr_g0 | rd_g0;
  assign Req1_Ready = wr_g1 | rd_g1;

  // Address/data hold their last granted value on idle cycles.
  assign Ram_WA      = wr_g1 ? Req1_Addr : (wr_g0 ? Req0_Addr : wa_q);
  assign Ram_WD      = wr_g1 ? Req1_WD   : (wr_g0 ? Req0_WD   : wd_q);
  assign Ram_WEN     = wr_g1 ? Req1_Ben  : (wr_g0 ? Req0_Ben  : '0);
  assign Ram_WClk_En = wr_any;
  assign Ram_RA      = rd_g1 ? Req1_Addr : (rd_g0 ? Req0_Addr : ra_q);
  assign Ram_RClk_En = rd_any;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      ra_q     <= '0;
      rsp_pend <= 1'b0;
      rsp_tag  <= 1'b0;
    end else begin
      if (wr_any) begin
        wr_ptr <= wr_g0;  // loser becomes preferred
        wa_q   <= Ram_WA;
        wd_q   <= Ram_WD;
      end
      if (rd_any) begin
        rd_ptr  <= rd_g0;
        ra_q    <= Ram_RA;
        rsp_tag <= rd_g1;
      end
      rsp_pend <= rd_any;
    end
  end

`ifdef RAM_ARB_WR_BYPASS_EN
  logic              byp_hit_q;
  logic [BEN_W-1:0]  byp_ben_q;
  logic [DATA_W-1:0] byp_wd_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      byp_hit_q <= 1'b0;
      byp_ben_q <= '0;
      byp_wd_q  <= '0;
    end else begin
      byp_hit_q <= wr_any & rd_any & (Ram_WA == Ram_RA);
      byp_ben_q <= Ram_WEN;
      byp_wd_q  <= Ram_WD;
    end
  end

  // Bytes written in the colliding cycle come from the captured write data.
  always_comb begin
    rd_data = Ram_RD;
    if (byp_hit_q) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (byp_ben_q[b]) rd_data[8*b +: 8] = byp_wd_q[8*b +: 8];
      end
    end
  end
`else
  assign rd_data = Ram_RD;
`endif

  assign Rsp0_Valid = rsp_pend & ~rsp_tag;
  assign Rsp1_Valid = rsp_pend &  rsp_tag;
  assign Rsp0_RD    = Rsp0_Valid ? rd_data : '0;
  assign Rsp1_RD    = Rsp1_Valid ? rd_data : '0;

endmodule

// File: tb/tb_ram_arb_2req.sv
// Testbench for ram_arb_2req. Includes a behavioural 512x16 RAM (registered
// read, read-old on collision, byte-enabled write) attached to the RAM ports.
module tb_ram_arb_2req;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req0_Valid, Req0_Ready, Req0_We;
  logic [8:0]  Req0_Addr;
  logic [15:0] Req0_WD;
  logic [1:0]  Req0_Ben;
  logic        Req1_Valid, Req1_Ready, Req1_We;
  logic [8:0]  Req1_Addr;
  logic [15:0] Req1_WD;
  logic [1:0]  Req1_Ben;
  logic        Rsp0_Valid, Rsp1_Valid;
  logic [15:0] Rsp0_RD, Rsp1_RD;
  logic [8:0]  Ram_WA, Ram_RA;
  logic [15:0] Ram_WD, Ram_RD;
  logic [1:0]  Ram_WEN;
  logic        Ram_RClk_En, Ram_WClk_En;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  ram_arb_2req dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_We(Req0_We),
    .Req0_Addr(Req0_Addr), .Req0_WD(Req0_WD), .Req0_Ben(Req0_Ben),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_We(Req1_We),
    .Req1_Addr(Req1_Addr), .Req1_WD(Req1_WD), .Req1_Ben(Req1_Ben),
    .Rsp0_Valid(Rsp0_Valid), .Rsp0_RD(Rsp0_RD),
    .Rsp1_Valid(Rsp1_Valid), .Rsp1_RD(Rsp1_RD),
    .Ram_WA(Ram_WA), .Ram_WD(Ram_WD), .Ram_WEN(Ram_WEN), .Ram_RA(Ram_RA),
    .Ram_RClk_En(Ram_RClk_En), .Ram_WClk_En(Ram_WClk_En), .Ram_RD(Ram_RD)
  );

  logic [15:0] mem [0:511];
  logic [15:0] ram_rd_q = 16'h0;
  always @(posedge Clk) begin
    if (Ram_RClk_En) ram_rd_q <= mem[Ram_RA];
    if (Ram_WClk_En) begin
      for (int b = 0; b < 2; b++)
        if (Ram_WEN[b]) mem[Ram_WA][8*b +: 8] <= Ram_WD[8*b +: 8];
    end
  end
  assign Ram_RD = ram_rd_q;

  task step;
    @(posedge Clk);
    #1;
  endtask

  task idle;
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
  endtask

  task set_req(input int r, input logic we, input logic [8:0] a,
               input logic [15:0] d, input logic [1:0] be);
    if (r == 0) begin
      Req0_Valid = 1'b1; Req0_We = we; Req0_Addr = a; Req0_WD = d; Req0_Ben = be;
    end else begin
      Req1_Valid = 1'b1; Req1_We = we; Req1_Addr = a; Req1_WD = d; Req1_Ben = be;
    end
  endtask

  task wr(input int r, input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
    set_req(r, 1'b1, a, d, be);
    step;
    idle;
  endtask

  task test_reset;
    Rst_n = 1'b0;
    idle;
    Req0_We = 0; Req0_Addr = 0; Req0_WD = 0; Req0_Ben = 0;
    Req1_We = 0; Req1_Addr = 0; Req1_WD = 0; Req1_Ben = 0;
    step; step;
    set_req(0, 1'b1, 9'h003, 16'h1234, 2'b11);
    #2;
    n_chk++; if (Req0_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got %b exp 0", Req0_Ready); end
    n_chk++; if (Ram_WClk_En !== 1'b0) begin n_fail++; $display("FAIL rst_wclk_en got %b exp 0", Ram_WClk_En); end
    n_chk++; if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b%b exp 00", Rsp0_Valid, Rsp1_Valid); end
    n_chk++; if (Rsp0_RD !== 16'h0 || Rsp1_RD !== 16'h0) begin n_fail++; $display("FAIL rst_rsp_rd got %h %h exp 0000 0000", Rsp0_RD, Rsp1_RD); end
    idle;
    step;
    Rst_n = 1'b1;
    #2;
    n_chk++; if (Ram_RClk_En !== 1'b0 || Ram_WEN !== 2'b00) begin n_fail++; $display("FAIL idle_ram got %b %b exp 0 00", Ram_RClk_En, Ram_WEN); end
    step;
  endtask

  task test_basic;
    set_req(0, 1'b1, 9'h005, 16'hA5C3, 2'b11);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin n_fail++; $display("FAIL basic_wr_ready got %b%b exp 10", Req0_Ready, Req1_Ready); end
    n_chk++; if (Ram_WClk_En !== 1'b1 || Ram_WA !== 9'h005 || Ram_WD !== 16'hA5C3 || Ram_WEN !== 2'b11)
      begin n_fail++; $display("FAIL basic_wr_drive got en=%b wa=%h wd=%h wen=%b exp 1 005 a5c3 11", Ram_WClk_En, Ram_WA, Ram_WD, Ram_WEN); end
    n_chk++; if (Ram_RClk_En !== 1'b0) begin n_fail++; $display("FAIL basic_wr_no_read got %b exp 0", Ram_RClk_En); end
    step;
    idle;
    #2;
    n_chk++; if (Ram_WClk_En !== 1'b0 || Ram_WEN !== 2'b00 || Ram_WA !== 9'h005 || Ram_WD !== 16'hA5C3)
      begin n_fail++; $display("FAIL basic_wr_hold got en=%b wen=%b wa=%h wd=%h exp 0 00 005 a5c3", Ram_WClk_En, Ram_WEN, Ram_WA, Ram_WD); end
    step;
    set_req(1, 1'b0, 9'h005, 16'h0, 2'b00);
    #2;
    n_chk++; if (Req1_Ready !== 1'b1 || Req0_Ready !== 1'b0) begin n_fail++; $display("FAIL basic_rd_ready got %b%b exp 01", Req0_Ready, Req1_Ready); end
    n_chk++; if (Ram_RClk_En !== 1'b1 || Ram_RA !== 9'h005) begin n_fail++; $display("FAIL basic_rd_drive got en=%b ra=%h exp 1 005", Ram_RClk_En, Ram_RA); end
    n_chk++; if (Rsp1_Valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_early got %b exp 0", Rsp1_Valid); end
    step;
    idle;
    n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp1_RD !== 16'hA5C3) begin n_fail++; $display("FAIL basic_rsp1 got v=%b rd=%h exp 1 a5c3", Rsp1_Valid, Rsp1_RD); end
    n_chk++; if (Rsp0_Valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp0_quiet got %b exp 0", Rsp0_Valid); end
    step;
    n_chk++; if (Rsp1_Valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_pulse got %b exp 0", Rsp1_Valid); end
  endtask

  task test_byte_enables;
    wr(0, 9'h010, 16'hFFFF, 2'b11);
    wr(1, 9'h010, 16'h1234, 2'b01);
    set_req(0, 1'b1, 9'h010, 16'h0000, 2'b00);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Ram_WEN !== 2'b00) begin n_fail++; $display("FAIL ben00_grant got rdy=%b wen=%b exp 1 00", Req0_Ready, Ram_WEN); end
    step;
    idle;
    set_req(1, 1'b0, 9'h010, 16'h0, 2'b00);
    step;
    idle;
    n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp1_RD !== 16'hFF34) begin n_fail++; $display("FAIL ben_readback got v=%b rd=%h exp 1 ff34", Rsp1_Valid, Rsp1_RD); end
    step;
  endtask

  task test_contention;
    wr(0, 9'h001, 16'h1111, 2'b11);
    wr(1, 9'h002, 16'h2222, 2'b11);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        set_req(0, 1'b0, 9'h001, 16'h0, 2'b00);
        set_req(1, 1'b0, 9'h002, 16'h0, 2'b00);
      end else begin
        idle;
      end
      #2;
      if (k < 4) begin
        n_chk++; if (Req0_Ready !== (k % 2 == 0) || Req1_Ready !== (k % 2 == 1))
          begin n_fail++; $display("FAIL cont_grant k=%0d got %b%b exp %b%b", k, Req0_Ready, Req1_Ready, k % 2 == 0, k % 2 == 1); end
      end
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          n_chk++; if (Rsp0_Valid !== 1'b1 || Rsp1_Valid !== 1'b0 || Rsp0_RD !== 16'h1111)
            begin n_fail++; $display("FAIL cont_rsp k=%0d got v=%b%b rd=%h exp 10 1111", k, Rsp0_Valid, Rsp1_Valid, Rsp0_RD); end
        end else begin
          n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp0_Valid !== 1'b0 || Rsp1_RD !== 16'h2222)
            begin n_fail++; $display("FAIL cont_rsp k=%0d got v=%b%b rd=%h exp 01 2222", k, Rsp0_Valid, Rsp1_Valid, Rsp1_RD); end
        end
      end
      step;
    end
    n_chk++; if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain got %b%b exp 00", Rsp0_Valid, Rsp1_Valid); end
  endtask

  task test_concurrent;
    wr(1, 9'h021, 16'h0F0F, 2'b11);
    set_req(0, 1'b1, 9'h020, 16'hBEEF, 2'b11);
    set_req(1, 1'b0, 9'h021, 16'h0, 2'b00);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b1) begin n_fail++; $display("FAIL conc_ready got %b%b exp 11", Req0_Ready, Req1_Ready); end
    step;
    idle;
    n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp1_RD !== 16'h0F0F || Rsp0_Valid !== 1'b0)
      begin n_fail++; $display("FAIL conc_rsp got v=%b%b rd=%h exp 01 0f0f", Rsp0_Valid, Rsp1_Valid, Rsp1_RD); end
    set_req(0, 1'b0, 9'h020, 16'h0, 2'b00);
    step;
    idle;
    n_chk++; if (Rsp0_Valid !== 1'b1 || Rsp0_RD !== 16'hBEEF) begin n_fail++; $display("FAIL conc_readback got v=%b rd=%h exp 1 beef", Rsp0_Valid, Rsp0_RD); end
    step;
  endtask

  task test_collision;
    logic [15:0] exp_rd;
`ifdef RAM_ARB_WR_BYPASS_EN
    exp_rd = 16'h2211;
`else
    exp_rd = 16'h1111;
`endif
    wr(0, 9'h030, 16'h1111, 2'b11);
    set_req(0, 1'b1, 9'h030, 16'h2222, 2'b10);
    set_req(1, 1'b0, 9'h030, 16'h0, 2'b00);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready got %b%b exp 11", Req0_Ready, Req1_Ready); end
    step;
    idle;
    n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp1_RD !== exp_rd) begin n_fail++; $display("FAIL coll_rsp got v=%b rd=%h exp 1 %h", Rsp1_Valid, Rsp1_RD, exp_rd); end
    step;
    set_req(1, 1'b0, 9'h030, 16'h0, 2'b00);
    step;
    idle;
    n_chk++; if (Rsp1_Valid !== 1'b1 || Rsp1_RD !== 16'h2211) begin n_fail++; $display("FAIL coll_readback got v=%b rd=%h exp 1 2211", Rsp1_Valid, Rsp1_RD); end
    step;
  endtask

  task test_reset_midflight;
    // Leave both pointers pointing at requester 1 before reset.
    wr(0, 9'h040, 16'h5555, 2'b11);
    set_req(0, 1'b0, 9'h040, 16'h0, 2'b00);
    step;
    idle;
    Rst_n = 1'b0;
    set_req(0, 1'b1, 9'h041, 16'h7777, 2'b11);
    #2;
    n_chk++; if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0 || Rsp0_RD !== 16'h0)
      begin n_fail++; $display("FAIL midrst_rsp got v=%b%b rd=%h exp 00 0000", Rsp0_Valid, Rsp1_Valid, Rsp0_RD); end
    n_chk++; if (Req0_Ready !== 1'b0 || Ram_WClk_En !== 1'b0 || Ram_RClk_En !== 1'b0)
      begin n_fail++; $display("FAIL midrst_quiet got rdy=%b wen=%b ren=%b exp 0 0 0", Req0_Ready, Ram_WClk_En, Ram_RClk_En); end
    step;
    n_chk++; if (Rsp0_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse got %b exp 0", Rsp0_Valid); end
    idle;
    step;
    Rst_n = 1'b1;
    set_req(0, 1'b1, 9'h041, 16'h0001, 2'b11);
    set_req(1, 1'b1, 9'h042, 16'h0002, 2'b11);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_ptr got %b%b exp 10", Req0_Ready, Req1_Ready); end
    step;
    idle;
    set_req(0, 1'b0, 9'h041, 16'h0, 2'b00);
    set_req(1, 1'b0, 9'h042, 16'h0, 2'b00);
    #2;
    n_chk++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_ptr got %b%b exp 10", Req0_Ready, Req1_Ready); end
    step;
    idle;
    n_chk++; if (Rsp0_Valid !== 1'b1 || Rsp0_RD !== 16'h0001) begin n_fail++; $display("FAIL midrst_rsp_after got v=%b rd=%h exp 1 0001", Rsp0_Valid, Rsp0_RD); end
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_enables;
    test_contention;
    test_concurrent;
    test_collision;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arb_2req.md
Name: ram_arb_2req

Overview:
- Two-requester arbiter and sequencer for the 512x16 simple-dual-port inferred RAM: one write port with 2-bit byte enables, one synchronous read port with 1-cycle latency.
- Each cycle it grants at most one write and one read, chosen independently with round-robin per port. It then routes the RAM read data back to the requester that issued the read.
- Sits between two bus masters (for example a DMA engine and a CPU-side port) and a single shared RAM instance.

Parameters:
- ADDR_W, 9, address width (depth = 2**ADDR_W).
- DATA_W, 16, data width; must be a multiple of 8.
- BEN_W, 2, byte-enable width (DATA_W/8).

Ports:
- Clk  in  1  single clock; drives arbiter and RAM WClk/RClk.
- Rst_n  in  1  asynchronous active-low reset.
- Req0_Valid / Req1_Valid  in  1  request present.
- Req0_Ready / Req1_Ready  out  1  request accepted this cycle (combinational grant).
- Req0_We / Req1_We  in  1  1 = write, 0 = read.
- Req0_Addr / Req1_Addr  in  ADDR_W  word address.
- Req0_WD / Req1_WD  in  DATA_W  write data.
- Req0_Ben / Req1_Ben  in  BEN_W  byte enables; bit0 covers [7:0], bit1 covers [15:8].
- Rsp0_Valid / Rsp1_Valid  out  1  read data valid; single-cycle pulse, no backpressure.
- Rsp0_RD / Rsp1_RD  out  DATA_W  read data; meaningful only while the matching Rsp*_Valid is high.
- Ram_WA  out  ADDR_W  RAM write address.
- Ram_WD  out  DATA_W  RAM write data.
- Ram_WEN  out  BEN_W  RAM byte write enables.
- Ram_RA  out  ADDR_W  RAM read address.
- Ram_RClk_En  out  1  RAM read enable.
- Ram_WClk_En  out  1  RAM write enable.
- Ram_RD  in  DATA_W  RAM read data (registered in RAM, 1-cycle latency).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Rsp*_Valid = 0, Rsp*_RD = 0.
  - Write RR pointer = 0 and read RR pointer = 0, i.e. requester 0 is preferred.
  - Read-tag register is cleared and any in-flight read response is discarded.
- Ready/grant, RAM outputs, and the RR pointers must all be inactive or hold while Rst_n is low.
- Classification: a request is a write candidate if Valid & We, and a read candidate if Valid & ~We.
- Write port arbitration:
  - Exactly one candidate: it is granted.
  - Both are candidates: the requester named by the write RR pointer is granted.
  - On any write grant, the write RR pointer becomes the non-granted index (1 - winner).
- Read port arbitration: identical, using its own read RR pointer.
- A write from one requester and a read from the other can be granted in the same cycle; throughput is 2 accesses per cycle maximum.
- Req*_Ready = grant. A transfer occurs when Valid & Ready are both high at the rising edge.
- Requester rule: the requester must hold Valid and its payload stable until Ready. The arbiter has no lock: a losing requester simply waits and wins the next contested cycle via RR.
- RAM drive when a write is granted: Ram_WA = Addr, Ram_WD = WD, Ram_WEN = Ben, Ram_WClk_En = 1.
- RAM drive with no write granted: Ram_WEN = 0, Ram_WClk_En = 0, and Ram_WA/Ram_WD hold their last value.
- Ben = 00 write: it is still granted and handshaken, with no RAM change.
- Read timing:
  - A read granted in cycle N drives Ram_RA = Addr and Ram_RClk_En = 1 in cycle N.
  - The granted index is registered as the tag.
  - In cycle N+1 the module asserts RspT_Valid = 1 and drives RspT_RD = Ram_RD; the other requester's Rsp stays at Valid = 0.
  - Back-to-back reads pipeline fully: one response per cycle, in grant order.
- Collision (write and read to the same address in the same cycle): the read returns the pre-write contents (read-old), unless the optional feature is enabled.
- Address wrap: none. Addresses are used modulo 2**ADDR_W as given.

Optional Feature:
- Macro: RAM_ARB_WR_BYPASS_EN.
- When defined: on a same-cycle, same-address write and read collision, the data is registered. In cycle N+1, Rsp*_RD is formed per byte: a byte with Ben set returns the new WD byte, and a byte with Ben clear returns the Ram_RD byte. This gives read-new semantics per byte.
- When undefined: no bypass logic and read-old semantics. The RTL must not instantiate bypass registers.

Test Plan:
- Reset, then Req0 writes Addr=0x005, WD=0xA5C3, Ben=11; then Req1 reads 0x005 → Req1 Ready the same cycle, Rsp1_Valid exactly 1 cycle later, Rsp1_RD = 0xA5C3, Rsp0_Valid = 0.
- Byte enables: write 0x010 = 0xFFFF, then write 0x010 = 0x1234 with Ben=01, then read → 0xFF34.
- Contention: both requesters hold a read for 4 cycles (Req0 at 0x001 = 0x1111, Req1 at 0x002 = 0x2222) → grants alternate 0,1,0,1; responses alternate with matching data, one per cycle.
- Concurrent write and read: Req0 writes 0x020 = 0xBEEF while Req1 reads 0x021 = 0x0F0F → both Ready in the same cycle; Rsp1_RD = 0x0F0F; 0x020 reads back 0xBEEF afterwards.
- Collision at 0x030 (old value 0x1111, write 0x2222, Ben=10) → Rsp_RD = 0x1111 without the macro, 0x2211 with RAM_ARB_WR_BYPASS_EN.
- Assert Rst_n low in the cycle after a read grant → no Rsp*_Valid pulse appears; RR pointers reset to 0, so Req0 wins the first contested cycle after release.
